// File: rtl/intra_recon_sequencer_if.sv
// Handshake bundle between the intra reconstruction sequencer and the
// surrounding datapath.
//   master : sequencer side (drives control, index, recon and output strobes)
//   slave  : environment side (front end, reconstructor, downstream sink)
// Signals:
//   start/busy/frame_done              frame control and status
//   mbnumber/pred_enable               extractor + predictor control
//   mode_in/mode_valid                 mode decision (no back-pressure)
//   residue_valid/residue_ready        residue block handshake
//   recon_enable/recon_mode            reconstructor strobe + latched mode
//   mb_valid/mb_ready/mb_count         finished block handshake + progress
interface intra_recon_sequencer_if;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [31:0] mbnumber;
  logic        pred_enable;
  logic [2:0]  mode_in;
  logic        mode_valid;
  logic        residue_valid;
  logic        residue_ready;
  logic        recon_enable;
  logic [2:0]  recon_mode;
  logic        mb_valid;
  logic        mb_ready;
  logic [31:0] mb_count;

  modport master (
    input  start, mode_in, mode_valid, residue_valid, mb_ready,
    output busy, frame_done, mbnumber, pred_enable, residue_ready,
           recon_enable, recon_mode, mb_valid, mb_count
  );

  modport slave (
    output start, mode_in, mode_valid, residue_valid, mb_ready,
    input  busy, frame_done, mbnumber, pred_enable, residue_ready,
           recon_enable, recon_mode, mb_valid, mb_count
  );
endinterface

// File: rtl/intra_recon_sequencer.sv
// Frame-level sequencer for intra reconstruction. Walks macroblocks in
// raster order: FETCH (predictor enabled for PRED_LATENCY cycles), WAIT
// (collect mode + residue in any order), RECON (one-cycle reconstructor
// strobe), DRAIN (remaining reconstruction latency), OUTPUT (valid/ready
// to downstream), then the next block or DONE.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - intra_recon_sequencer_if.master (all handshake/status signals)
module intra_recon_sequencer #(
  parameter int WIDTH         = 1280,
  parameter int LENGTH        = 720,
  parameter int MB_SIZE_W     = 4,
  parameter int MB_SIZE_L     = 4,
  parameter int PRED_LATENCY  = 2,
  parameter int RECON_LATENCY = 1
) (
  input logic                     clk,
  input logic                     reset,
  intra_recon_sequencer_if.master bus
);

  localparam int NUM_MB = (WIDTH / MB_SIZE_W) * (LENGTH / MB_SIZE_L);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_RECON, S_DRAIN, S_OUTPUT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [31:0] mbnumber_q;
  logic [31:0] mb_count_q;
  logic [2:0]  recon_mode_q;
  logic        mode_got, res_got;

  // Captures only count inside WAIT and only once per macroblock.
  logic mode_cap, res_cap, hs, last_mb, go;
  assign mode_cap = (state == S_WAIT) && bus.mode_valid && !mode_got;
  assign res_cap  = (state == S_WAIT) && bus.residue_valid && !res_got;
  assign hs       = (state == S_OUTPUT) && bus.mb_ready;
  assign last_mb  = (mbnumber_q == 32'(NUM_MB - 1));
  assign go       = (state == S_IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_FETCH;
      S_FETCH:  if (cnt == 32'd1) state_nxt = S_WAIT;
      // Counting same-cycle captures lets a block whose mode and residue
      // both arrive on the first WAIT cycle go straight to RECON.
      S_WAIT:   if ((mode_got || mode_cap) && (res_got || res_cap))
                  state_nxt = S_RECON;
      S_RECON:  state_nxt = (RECON_LATENCY > 1) ? S_DRAIN : S_OUTPUT;
      S_DRAIN:  if (cnt == 32'd1) state_nxt = S_OUTPUT;
      S_OUTPUT: if (bus.mb_ready) state_nxt = last_mb ? S_DONE : S_FETCH;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy          = (state != S_IDLE);
    bus.pred_enable   = (state == S_FETCH);
    bus.residue_ready = (state == S_WAIT) && !res_got;
    bus.recon_enable  = (state == S_RECON);
    bus.mb_valid      = (state == S_OUTPUT);
    bus.frame_done    = (state == S_DONE);
    bus.mbnumber      = mbnumber_q;
    bus.mb_count      = mb_count_q;
    bus.recon_mode    = recon_mode_q;
  end

  // Datapath: latency counter, block index, progress, captured mode/flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      mbnumber_q   <= '0;
      mb_count_q   <= '0;
      recon_mode_q <= '0;
      mode_got     <= 1'b0;
      res_got      <= 1'b0;
    end else begin
      if (go) begin
        cnt        <= 32'(PRED_LATENCY);
        mbnumber_q <= '0;
        mb_count_q <= '0;
        mode_got   <= 1'b0;
        res_got    <= 1'b0;
      end
      if (state == S_FETCH || state == S_DRAIN) cnt <= cnt - 32'd1;
      if (state == S_RECON) begin
        // DRAIN covers the latency beyond the RECON cycle itself.
        cnt      <= 32'(RECON_LATENCY - 1);
        mode_got <= 1'b0;
        res_got  <= 1'b0;
      end
      if (mode_cap) begin
        recon_mode_q <= bus.mode_in;
        mode_got     <= 1'b1;
      end
      if (res_cap) res_got <= 1'b1;
      if (hs) begin
        mb_count_q <= mb_count_q + 32'd1;
        // Index stops at the last block so it reads back after the frame.
        if (!last_mb) begin
          mbnumber_q <= mbnumber_q + 32'd1;
          cnt        <= 32'(PRED_LATENCY);
        end
      end
    end
  end

endmodule

// File: tb/tb_intra_recon_sequencer.sv
// Scoreboard bench for intra_recon_sequencer on an 8x8 frame (4 blocks).
// Expected {block, mode, count} entries are queued when stimulus for a
// block is driven and retired on each downstream handshake.
module tb_intra_recon_sequencer;
  localparam int W = 8, L = 8, PL = 2, RL = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  intra_recon_sequencer_if bus();

  intra_recon_sequencer #(
    .WIDTH(W), .LENGTH(L), .MB_SIZE_W(4), .MB_SIZE_L(4),
    .PRED_LATENCY(PL), .RECON_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mb;
    logic [2:0]  mode;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cycle = 0, fd_cnt = 0, last_hs = 0;
  bit   gap_chk = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock. The handshake is judged on the values the next
  // rising edge will see; frame_done is sampled after the edge.
  task automatic cyc();
    exp_t e;
    bit   popped;
    logic hs;
    popped = 1'b0;
    hs = bus.mb_valid && bus.mb_ready;
    if (hs) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        popped = 1'b1;
        chk("out_mb", bus.mbnumber, e.mb);
        chk("out_mode", 32'(bus.recon_mode), 32'(e.mode));
        if (gap_chk) chk("mb_period", 32'(cycle - last_hs), 32'd5);
        last_hs = cycle;
      end
    end
    @(negedge clk);
    cycle++;
    if (popped) chk("out_count", bus.mb_count, e.cnt);
    if (bus.frame_done) fd_cnt++;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"},       32'(bus.busy), 32'd0);
    chk({p, "_mbnumber"},   bus.mbnumber, 32'd0);
    chk({p, "_mb_count"},   bus.mb_count, 32'd0);
    chk({p, "_recon_mode"}, 32'(bus.recon_mode), 32'd0);
    chk({p, "_mb_valid"},   32'(bus.mb_valid), 32'd0);
    chk({p, "_pred_en"},    32'(bus.pred_enable), 32'd0);
    chk({p, "_res_ready"},  32'(bus.residue_ready), 32'd0);
    chk({p, "_recon_en"},   32'(bus.recon_enable), 32'd0);
    chk({p, "_frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  // Run through FETCH while pushing a stray start and a bogus mode 7;
  // both must be ignored. Returns on the first WAIT cycle.
  task automatic to_wait();
    int pe;
    pe = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.residue_ready) break;
      if (bus.pred_enable) pe++;
      bus.start      = 1'b1;
      bus.mode_valid = 1'b1;
      bus.mode_in    = 3'd7;
      cyc();
    end
    bus.start      = 1'b0;
    bus.mode_valid = 1'b0;
    chk("wait_reached", 32'(bus.residue_ready), 32'd1);
    chk("pred_cycles", 32'(pe), 32'(PL));
  endtask

  // One block: mode at WAIT cycle md (optionally a second, different mode
  // the cycle after), residue at cycle rd, downstream stalled rdy cycles.
  task automatic drive_mb(input int idx, input int md, input int rd,
                          input logic [2:0] m, input logic [2:0] m2,
                          input bit dbl, input int rdy);
    int k, mx;
    to_wait();
    chk("wait_mb", bus.mbnumber, 32'(idx));
    mx = (md > rd) ? md : rd;
    for (k = 0; k < 20; k++) begin
      bus.mode_valid    = (k == md) || (dbl && k == md + 1);
      bus.mode_in       = (k == md) ? m : m2;
      bus.residue_valid = (k == rd);
      cyc();
      if (bus.recon_enable) break;
      if (k >= rd) chk("res_ready_drop", 32'(bus.residue_ready), 32'd0);
    end
    bus.mode_valid    = 1'b0;
    bus.residue_valid = 1'b0;
    chk("recon_latency", 32'(k), 32'(mx));
    chk("recon_mode", 32'(bus.recon_mode), 32'(m));
    sb.push_back('{32'(idx), m, 32'(idx + 1)});
    bus.mb_ready = 1'b0;
    cyc();
    for (int i = 0; i < rdy; i++) begin
      chk("mb_valid_hold", 32'(bus.mb_valid), 32'd1);
      chk("mb_hold", bus.mbnumber, 32'(idx));
      cyc();
    end
    chk("mb_valid", 32'(bus.mb_valid), 32'd1);
    bus.mb_ready = 1'b1;
    cyc();
    bus.mb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.mode_in = 3'd0; bus.mode_valid = 1'b0;
    bus.residue_valid = 1'b0; bus.mb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // Frame 1: everything tied high, 5 cycles per block.
    for (int i = 0; i < 4; i++) sb.push_back('{32'(i), 3'd5, 32'(i + 1)});
    bus.mode_in = 3'd5; bus.mode_valid = 1'b1; bus.residue_valid = 1'b1;
    bus.mb_ready = 1'b1; bus.start = 1'b1;
    cycle = 0; last_hs = 0; gap_chk = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (29) cyc();
    gap_chk = 1'b0;
    bus.mode_valid = 1'b0; bus.residue_valid = 1'b0; bus.mb_ready = 1'b0;
    chk("t1_frame_done", 32'(fd_cnt), 32'd1);
    chk("t1_mb_count", bus.mb_count, 32'd4);
    chk("t1_mbnumber", bus.mbnumber, 32'd3);
    chk("t1_busy", 32'(bus.busy), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 2: ordering variations and downstream stalls.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    drive_mb(0, 0, 0, 3'd5, 3'd5, 1'b0, 0);  // same cycle
    drive_mb(1, 3, 0, 3'd2, 3'd2, 1'b0, 0);  // residue first
    drive_mb(2, 0, 3, 3'd1, 3'd6, 1'b1, 4);  // second mode ignored, stall 4
    drive_mb(3, 2, 2, 3'd4, 3'd4, 1'b0, 1);
    repeat (4) cyc();
    chk("t2_frame_done", 32'(fd_cnt), 32'd2);
    chk("t2_mb_count", bus.mb_count, 32'd4);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 3: abort by reset in WAIT of block 2, then a clean restart.
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    drive_mb(0, 0, 0, 3'd2, 3'd2, 1'b0, 0);
    drive_mb(1, 1, 0, 3'd3, 3'd3, 1'b0, 0);
    to_wait();
    chk("abort_mb", bus.mbnumber, 32'd2);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc();
    chk("abort_no_done", 32'(fd_cnt), 32'd2);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
    chk("restart_mb", bus.mbnumber, 32'd0);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    drive_mb(0, 1, 1, 3'd6, 3'd6, 1'b0, 0);
    drive_mb(1, 0, 2, 3'd0, 3'd3, 1'b1, 2);
    drive_mb(2, 2, 0, 3'd7, 3'd7, 1'b0, 0);
    drive_mb(3, 0, 0, 3'd1, 3'd1, 1'b0, 3);
    repeat (4) cyc();
    chk("t3_frame_done", 32'(fd_cnt), 32'd3);
    chk("t3_mb_count", bus.mb_count, 32'd4);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
